dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the CPU load/store path and an external host port (debug/loader).
- Generates the CPU stall that freezes PC and register write-back.
- Arbitration uses fixed CPU priority with a host anti-starvation counter.
- Sits between the datapath's load/store signals (address, store data, MemRead/MemWrite/BH) and the data-memory instance. Memory has synchronous reads: data is valid one cycle after issue.

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the CPU
// load/store path and a 4-phase host port, and generates the CPU stall.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_bh,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic        host_we,
  input  logic        host_bh,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata,
  output logic        host_ack,
  input  logic        host_hold,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_bh,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    HOST_RD,
    HOST_WR
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nx;
  logic [CNT_W-1:0] starve_inc;
  logic [15:0]      rdata_q;

  logic cpu_req;
  logic cpu_elig;
  logic host_elig;
  logic starved;
  logic idle;
  logic cpu_win;
  logic host_win;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign cpu_elig  = cpu_req & ~host_hold;
  assign host_elig = host_req & ~host_ack;
  assign starved   = starve_cnt >= CNT_W'(STARVE_MAX);
  assign idle      = (state == IDLE) & reset;

  // Nothing is issued while reset is held, so mem_* stay low.
  assign cpu_win  = idle & cpu_elig & ~(host_elig & starved);
  assign host_win = idle & host_elig & ~cpu_win;

  assign starve_inc = starved ? starve_cnt
                              : starve_cnt + CNT_W'(1);

  assign cpu_rdata = (state == CPU_RD) ? mem_rdata : rdata_q;

  // A store retires in its issue cycle; a load retires in CPU_RD.
  assign cpu_stall = reset & cpu_req
                   & (state != CPU_RD)
                   & ~(cpu_win & ~cpu_rd);

  always_comb begin
    state_nx  = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_bh    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    misalign  = 1'b0;
    unique case (1'b1)
      cpu_win: begin
        mem_rd    = cpu_rd;
        mem_wr    = ~cpu_rd;
        mem_bh    = cpu_bh;
        mem_addr  = {cpu_addr[15:1],
                     cpu_addr[0] & ~cpu_bh};
        mem_wdata = cpu_wdata;
        misalign  = cpu_bh & cpu_addr[0];
        if (cpu_rd) state_nx = CPU_RD;
      end
      host_win: begin
        mem_rd    = ~host_we;
        mem_wr    = host_we;
        mem_bh    = host_bh;
        mem_addr  = {host_addr[15:1],
                     host_addr[0] & ~host_bh};
        mem_wdata = host_wdata;
        misalign  = host_bh & host_addr[0];
        state_nx  = host_we ? HOST_WR : HOST_RD;
      end
      default: begin
        if (state != IDLE) state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    starve_nx = starve_cnt;
    if (!host_elig || host_win) begin
      starve_nx = '0;
    end else if (cpu_win || state == CPU_RD) begin
      starve_nx = starve_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      host_ack   <= 1'b0;
      host_rdata <= 16'h0000;
      rdata_q    <= 16'h0000;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_nx;
      if (state == CPU_RD) rdata_q <= mem_rdata;
      if (state == HOST_RD) host_rdata <= mem_rdata;
      if (state == HOST_RD || state == HOST_WR) begin
        host_ack <= 1'b1;
      end else if (host_ack && !host_req) begin
        host_ack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected memory issues are queued by
// the stimulus and checked by an independent monitor.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr, cpu_bh;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        host_req, host_we, host_bh;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic        host_ack, host_hold;
  logic        mem_rd, mem_wr, mem_bh;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        misalign;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_bh(cpu_bh),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we),
    .host_bh(host_bh), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_ack(host_ack), .host_hold(host_hold),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_bh(mem_bh),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .misalign(misalign)
  );

  // Memory model with synchronous read
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_wr) begin
      if (mem_bh) mem[mem_addr[8:1]] <= mem_wdata;
      else if (mem_addr[0]) mem[mem_addr[8:1]][15:8] <= mem_wdata[7:0];
      else mem[mem_addr[8:1]][7:0] <= mem_wdata[7:0];
    end
    if (mem_rd) mem_rdata <= mem[mem_addr[8:1]];
  end

  typedef struct {
    logic        rd, wr, bh, mis, stall, host, ret;
    logic [15:0] addr, wdata, rdata;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic rd, input logic wr, input logic bh,
                      input logic mis, input logic stall,
                      input logic host, input logic ret,
                      input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [15:0] rdata);
    exp_t e;
    e.rd = rd; e.wr = wr; e.bh = bh; e.mis = mis; e.stall = stall;
    e.host = host; e.ret = ret;
    e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    q.push_back(e);
  endtask

  // Monitor
  exp_t mon_e;
  exp_t cpu_pend;
  exp_t host_pend;
  int   cpu_ph = 0;
  int   host_ph = 0;

  always @(negedge clk) begin
    if (cpu_ph == 1) begin
      chk("load_ret_stall", 32'(cpu_stall), 32'(0));
      chk("load_ret_data", 32'(cpu_rdata), 32'(cpu_pend.rdata));
      cpu_ph = 0;
    end
    if (host_ph == 2) begin
      chk("host_ack_set", 32'(host_ack), 32'(1));
      if (!host_pend.wr)
        chk("host_rdata", 32'(host_rdata), 32'(host_pend.rdata));
      host_ph = 0;
    end
    if (host_ph == 1) begin
      chk("host_ack_early", 32'(host_ack), 32'(0));
      host_ph = 2;
    end
    if (mem_rd || mem_wr) begin
      if (q.size() == 0) begin
        chk("unexpected_issue", {30'd0, mem_rd, mem_wr}, 32'(0));
      end else begin
        mon_e = q.pop_front();
        chk("issue_rd", 32'(mem_rd), 32'(mon_e.rd));
        chk("issue_wr", 32'(mem_wr), 32'(mon_e.wr));
        chk("issue_bh", 32'(mem_bh), 32'(mon_e.bh));
        chk("issue_addr", 32'(mem_addr), 32'(mon_e.addr));
        if (mon_e.wr) chk("issue_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
        chk("issue_misalign", 32'(misalign), 32'(mon_e.mis));
        chk("issue_stall", 32'(cpu_stall), 32'(mon_e.stall));
        if (mon_e.host) begin
          host_pend = mon_e;
          host_ph = 1;
        end else if (mon_e.rd && mon_e.ret) begin
          cpu_pend = mon_e;
          cpu_ph = 1;
        end
      end
    end else if (misalign) begin
      chk("misalign_idle", 32'(misalign), 32'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string nm);
    for (int i = 0; i < 12; i++) begin
      if (host_ack == lvl) break;
      step();
    end
    chk(nm, 32'(host_ack), 32'(lvl));
  endtask

  initial begin
    int idx;
    int cyc;
    int stall_cyc;
    bit drop;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset = 1'b0;
    cpu_rd = 0; cpu_wr = 0; cpu_bh = 0;
    cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_bh = 0;
    host_addr = 0; host_wdata = 0; host_hold = 0;

    // Reset state, with a pending store already presented
    cpu_wr = 1; cpu_bh = 1;
    cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    repeat (2) step();
    @(negedge clk);
    chk("rst_stall", 32'(cpu_stall), 32'(0));
    chk("rst_mem_wr", 32'(mem_wr), 32'(0));
    chk("rst_ack", 32'(host_ack), 32'(0));
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
    chk("rst_host_rdata", 32'(host_rdata), 32'(0));
    chk("rst_misalign", 32'(misalign), 32'(0));

    // Store 0xBEEF to 0x0010 right after release
    push(0, 1, 1, 0, 0, 0, 0, 16'h0010, 16'hBEEF, 16'h0);
    step();
    reset = 1'b1;
    step();
    cpu_wr = 0;

    // Load it back
    push(1, 0, 1, 0, 1, 0, 1, 16'h0010, 16'h0, 16'hBEEF);
    cpu_rd = 1;
    step();
    step();
    cpu_rd = 0;

    // Host write, CPU idle
    push(0, 1, 1, 0, 0, 1, 0, 16'h0020, 16'h1234, 16'h0);
    host_req = 1; host_we = 1; host_bh = 1;
    host_addr = 16'h0020; host_wdata = 16'h1234;
    wait_ack(1, "host_wr_ack");
    step();
    step();
    chk("ack_held", 32'(host_ack), 32'(1));
    host_req = 0;
    step();
    chk("ack_clear", 32'(host_ack), 32'(0));

    // Starvation: CPU stores every cycle, host read pending
    for (int i = 0; i < 4; i++)
      push(0, 1, 1, 0, 0, 0, 0, 16'(16'h0040 + 2 * i),
           16'(16'h1000 + i), 16'h0);
    push(1, 0, 1, 0, 1, 1, 0, 16'h0010, 16'h0, 16'hBEEF);
    for (int i = 4; i < 6; i++)
      push(0, 1, 1, 0, 0, 0, 0, 16'(16'h0040 + 2 * i),
           16'(16'h1000 + i), 16'h0);
    host_req = 1; host_we = 0; host_addr = 16'h0010;
    idx = 0; cyc = 0; stall_cyc = -1; drop = 0;
    while (idx < 6 && cyc < 30) begin
      cpu_addr = 16'(16'h0040 + 2 * idx);
      cpu_wdata = 16'(16'h1000 + idx);
      cpu_wr = 1;
      @(negedge clk);
      if (cpu_stall && stall_cyc < 0) stall_cyc = cyc;
      if (!cpu_stall) idx++;
      if (host_ack) drop = 1;
      step();
      cyc++;
      if (drop) host_req = 0;
    end
    cpu_wr = 0;
    chk("starve_stores", 32'(idx), 32'(6));
    chk("starve_grant_cyc", 32'(stall_cyc), 32'(4));
    chk("starve_cnt_clr", 32'(dut.starve_cnt), 32'(0));
    chk("starve_ack_clr", 32'(host_ack), 32'(0));

    // host_hold: CPU load blocked, host still served
    host_hold = 1;
    cpu_rd = 1; cpu_bh = 1; cpu_addr = 16'h0020;
    push(0, 1, 1, 0, 1, 1, 0, 16'h0050, 16'h5555, 16'h0);
    host_req = 1; host_we = 1; host_bh = 1;
    host_addr = 16'h0050; host_wdata = 16'h5555;
    wait_ack(1, "hold_host_ack");
    chk("hold_stall", 32'(cpu_stall), 32'(1));
    host_req = 0;
    wait_ack(0, "hold_ack_clr");
    step();
    @(negedge clk);
    chk("hold_no_rd", 32'(mem_rd), 32'(0));
    chk("hold_stall2", 32'(cpu_stall), 32'(1));
    step();
    push(1, 0, 1, 0, 1, 0, 1, 16'h0020, 16'h0, 16'h1234);
    host_hold = 0;
    @(negedge clk);
    chk("release_rd", 32'(mem_rd), 32'(1));
    step();
    step();
    cpu_rd = 0;

    // Misaligned halfword, aligned byte, rd+wr together
    push(0, 1, 1, 1, 0, 0, 0, 16'h0030, 16'hA5A5, 16'h0);
    cpu_wr = 1; cpu_bh = 1; cpu_addr = 16'h0031; cpu_wdata = 16'hA5A5;
    step();
    push(0, 1, 0, 0, 0, 0, 0, 16'h0033, 16'h00C3, 16'h0);
    cpu_bh = 0; cpu_addr = 16'h0033; cpu_wdata = 16'h00C3;
    step();
    push(1, 0, 1, 0, 1, 0, 1, 16'h0030, 16'h0, 16'hA5A5);
    cpu_rd = 1; cpu_bh = 1; cpu_addr = 16'h0030; cpu_wdata = 16'hFFFF;
    step();
    step();
    cpu_rd = 0; cpu_wr = 0;

    // Reset during CPU_RD abandons the read
    push(1, 0, 1, 0, 1, 0, 0, 16'h0030, 16'h0, 16'h0);
    cpu_rd = 1; cpu_addr = 16'h0030;
    step();
    reset = 1'b0;
    cpu_rd = 0;
    #1;
    chk("rst2_stall", 32'(cpu_stall), 32'(0));
    chk("rst2_mem_rd", 32'(mem_rd), 32'(0));
    chk("rst2_ack", 32'(host_ack), 32'(0));
    chk("rst2_rdata", 32'(cpu_rdata), 32'(0));
    step();
    reset = 1'b1;
    repeat (4) step();
    chk("rst2_no_ack", 32'(host_ack), 32'(0));
    chk("queue_empty", 32'(q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
